// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: FSM encoding and stats width.
package rf_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_PEND  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_e;

  localparam int STATS_W = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for long-unit destinations: one set port, one clear port,
// two RAW lookups and one WAW lookup.
module rf_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic [ADDR_W-1:0]      raddr1,
  input  logic [ADDR_W-1:0]      raddr2,
  input  logic [ADDR_W-1:0]      waw_addr,
  output logic                   busy1,
  output logic                   busy2,
  output logic                   busy_waw,
  output logic [2**ADDR_W-1:0]   busy_vec
);

  logic [2**ADDR_W-1:0] busy_q;

  // NOTE: sequential state uses non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (clr_en) busy_q[clr_addr] <= 1'b0;
      // r0 is hard-wired zero and therefore never tracked.
      if (set_en && (set_addr != '0)) busy_q[set_addr] <= 1'b1;
    end
  end

  assign busy1    = busy_q[raddr1];
  assign busy2    = busy_q[raddr2];
  assign busy_waw = busy_q[waw_addr];
  assign busy_vec = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between pipeline WB and long-unit results.
// Optional RF_ARB_STATS_EN adds a saturating conflict_cnt output.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_we,
  input  logic [ADDR_W-1:0]    wb_waddr,
  input  logic [DATA_W-1:0]    wb_wdata,
  input  logic                 lu_issue,
  input  logic [ADDR_W-1:0]    lu_issue_waddr,
  output logic                 lu_issue_stall,
  input  logic                 lu_valid,
  output logic                 lu_ready,
  input  logic [ADDR_W-1:0]    lu_waddr,
  input  logic [DATA_W-1:0]    lu_wdata,
  input  logic [ADDR_W-1:0]    rd_raddr1,
  input  logic [ADDR_W-1:0]    rd_raddr2,
  output logic                 rd_stall,
  output logic                 pipe_hold,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] busy_vec
`ifdef RF_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]   conflict_cnt
`endif
);

  localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT);

  arb_state_e          state;
  logic [CNT_W-1:0]    starve_cnt;
  logic [ADDR_W-1:0]   buf_waddr;
  logic [DATA_W-1:0]   buf_wdata;

  logic wb_req, buf_valid, buf_commit, accept, grant_wb;
  logic busy1, busy2, busy_waw;

  assign wb_req     = wb_we && (wb_waddr != '0);
  assign buf_valid  = (state != ARB_IDLE);
  assign buf_commit = (state == ARB_FORCE) || ((state == ARB_PEND) && !wb_req);
  assign lu_ready   = !buf_valid || buf_commit;
  // Results to r0 complete the handshake but are never buffered.
  assign accept     = lu_valid && lu_ready && (lu_waddr != '0);
  assign grant_wb   = wb_req && (state != ARB_FORCE);
  assign pipe_hold  = (state == ARB_FORCE);

  assign rf_we    = grant_wb || buf_commit;
  assign rf_waddr = grant_wb ? wb_waddr : (buf_commit ? buf_waddr : '0);
  assign rf_wdata = grant_wb ? wb_wdata : (buf_commit ? buf_wdata : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (accept) state <= ARB_PEND;
          starve_cnt <= '0;
        end
        ARB_PEND: begin
          if (!wb_req) begin
            state      <= accept ? ARB_PEND : ARB_IDLE;
            starve_cnt <= '0;
          end else if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
            state <= ARB_FORCE;
          end else begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        ARB_FORCE: begin
          state      <= accept ? ARB_PEND : ARB_IDLE;
          starve_cnt <= '0;
        end
        default: begin
          state      <= ARB_IDLE;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  // NOTE: buffer payload needs no reset; it is only observed while the FSM says it is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_waddr <= lu_waddr;
      buf_wdata <= lu_wdata;
    end
  end

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (lu_issue && !busy_waw),
    .set_addr (lu_issue_waddr),
    .clr_en   (buf_commit),
    .clr_addr (buf_waddr),
    .raddr1   (rd_raddr1),
    .raddr2   (rd_raddr2),
    .waw_addr (lu_issue_waddr),
    .busy1    (busy1),
    .busy2    (busy2),
    .busy_waw (busy_waw),
    .busy_vec (busy_vec)
  );

  assign lu_issue_stall = lu_issue && busy_waw;

  // A register committing from the buffer this cycle is covered by regfile write-through.
  assign rd_stall = ((rd_raddr1 != '0) && busy1 && !(buf_commit && (buf_waddr == rd_raddr1))) ||
                    ((rd_raddr2 != '0) && busy2 && !(buf_commit && (buf_waddr == rd_raddr2)));

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if ((state == ARB_PEND) && wb_req && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized plus directed bench for rf_wb_arbiter against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              lu_issue;
  logic [ADDR_W-1:0] lu_issue_waddr;
  logic              lu_issue_stall;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  logic [ADDR_W-1:0] rd_raddr1, rd_raddr2;
  logic              rd_stall, pipe_hold, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [31:0]       busy_vec;
`ifdef RF_ARB_STATS_EN
  logic [31:0]       conflict_cnt;
`endif

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_issue(lu_issue), .lu_issue_waddr(lu_issue_waddr), .lu_issue_stall(lu_issue_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rd_raddr1(rd_raddr1), .rd_raddr2(rd_raddr2), .rd_stall(rd_stall), .pipe_hold(pipe_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
`ifdef RF_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending results as a queue, busy registers as a bit set,
  // a run-length of WB wins over a waiting result, and a "forced" flag.
  typedef struct {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} res_t;
  res_t        buf_q[$];
  logic [31:0] m_busy   = '0;
  int          m_losses = 0;
  bit          m_force  = 0;
  longint      m_conflicts = 0;
  bit          m_accept, m_issued;

  task automatic step();
    bit wb_req, has_buf, commit, e_we, e_ready, e_stall, e_rd;
    logic [ADDR_W-1:0] e_addr, r;
    logic [DATA_W-1:0] e_data;
    res_t head;
    #1;
    wb_req  = wb_we && (wb_waddr != 0);
    has_buf = buf_q.size() != 0;
    head    = has_buf ? buf_q[0] : '{a: '0, d: '0};
    commit  = has_buf && (m_force || !wb_req);
    e_we    = commit || wb_req;
    e_addr  = commit ? head.a : wb_waddr;
    e_data  = commit ? head.d : wb_wdata;
    e_ready = !has_buf || commit;
    e_stall = lu_issue && m_busy[lu_issue_waddr];
    e_rd    = 0;
    for (int k = 0; k < 2; k++) begin
      r = (k == 0) ? rd_raddr1 : rd_raddr2;
      if (r != 0 && m_busy[r] && !(commit && head.a == r)) e_rd = 1;
    end
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_waddr", rf_waddr, e_addr);
      check("rf_wdata", rf_wdata, e_data);
    end
    check("lu_ready", lu_ready, e_ready);
    check("pipe_hold", pipe_hold, m_force);
    check("lu_issue_stall", lu_issue_stall, e_stall);
    check("rd_stall", rd_stall, e_rd);
    check("busy_vec", busy_vec, m_busy);
`ifdef RF_ARB_STATS_EN
    check("conflict_cnt", conflict_cnt, (m_conflicts > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_conflicts);
`endif
    m_accept = lu_valid && e_ready && !rst;
    m_issued = lu_issue && !e_stall && !rst;
    @(posedge clk);
    if (rst) begin
      buf_q.delete();
      m_busy = '0; m_losses = 0; m_force = 0; m_conflicts = 0;
    end else begin
      if (commit) begin
        m_busy[head.a] = 1'b0;
        void'(buf_q.pop_front());
        m_force = 0;
      end else if (has_buf && wb_req) begin
        m_conflicts++;
        m_losses++;
        if (m_losses >= LIMIT) m_force = 1;
      end
      if (m_accept && lu_waddr != 0) begin
        buf_q.push_back('{a: lu_waddr, d: lu_wdata});
        m_losses = 0;
      end
      if (m_issued && lu_issue_waddr != 0) m_busy[lu_issue_waddr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    lu_issue = 0; lu_issue_waddr = 0; lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
    rd_raddr1 = 0; rd_raddr2 = 0;
  endtask

  logic [ADDR_W-1:0] out_q[$];
  bit                pres_valid;
  logic [ADDR_W-1:0] pres_addr;
  logic [DATA_W-1:0] pres_data;
  int                hold_seen;

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    step();                                   // reset state

    // WB only: r5 = 0x11 every cycle
    wb_we = 1; wb_waddr = 5; wb_wdata = 32'h11;
    hold_seen = 0;
    repeat (4) begin hold_seen += int'(pipe_hold); step(); end
    check("wb_only_hold", 64'(hold_seen), 0);
    idle_inputs();

    // Issue r8, RAW stall, result 0xAB, commit next cycle
    lu_issue = 1; lu_issue_waddr = 8; step();
    lu_issue = 0; rd_raddr1 = 8; step();
    lu_valid = 1; lu_waddr = 8; lu_wdata = 32'hAB; step();
    lu_valid = 0; step();
    step();

    // Starvation: buffer full, WB busy -> one FORCE cycle
    idle_inputs();
    lu_valid = 1; lu_waddr = 7; lu_wdata = 32'h77; step();
    lu_valid = 0; wb_we = 1; wb_waddr = 12; wb_wdata = 32'h5A5A;
    hold_seen = 0;
    repeat (LIMIT + 2) begin hold_seen += int'(pipe_hold); step(); end
    check("starve_hold_cycles", 64'(hold_seen), 1);
    idle_inputs();

    // WAW on r3, r0 issue never stalls nor sets busy
    lu_issue = 1; lu_issue_waddr = 3; step();
    step();
    lu_issue_waddr = 0; step();
    lu_issue = 0; lu_valid = 1; lu_waddr = 3; lu_wdata = 32'h33; step();
    lu_valid = 0; step();

    // Back-to-back results with WB idle, plus a dropped r0 result
    for (int i = 1; i <= 4; i++) begin
      lu_valid = 1; lu_waddr = ADDR_W'(i + 16); lu_wdata = 32'h100 + i; step();
    end
    lu_waddr = 0; lu_wdata = 32'hDEAD; step();
    lu_valid = 0; step();
    step();

    // Reset while PEND with busy[9]
    lu_issue = 1; lu_issue_waddr = 9; step();
    lu_issue = 0; wb_we = 1; wb_waddr = 4; wb_wdata = 32'h44;
    lu_valid = 1; lu_waddr = 9; lu_wdata = 32'h99; step();
    lu_valid = 0; rst = 1; step();
    idle_inputs(); rd_raddr1 = 9; step();
    step();

    // Randomized traffic; results return in issue order after random delays
    pres_valid = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pres_valid && out_q.size() != 0 && ($urandom % 3) != 0) begin
        pres_addr  = out_q.pop_front();
        pres_data  = $urandom;
        pres_valid = 1;
      end
      rst            = (($urandom % 400) == 0);
      lu_valid       = pres_valid;
      lu_waddr       = pres_valid ? pres_addr : ADDR_W'($urandom % 32);
      lu_wdata       = pres_valid ? pres_data : $urandom;
      lu_issue       = (($urandom % 3) == 0);
      lu_issue_waddr = ADDR_W'($urandom % 8);
      wb_we          = (($urandom % 4) != 0);
      wb_waddr       = ADDR_W'($urandom % 32);
      wb_wdata       = $urandom;
      rd_raddr1      = ADDR_W'($urandom % 8);
      rd_raddr2      = ADDR_W'($urandom % 8);
      step();
      if (m_accept) pres_valid = 0;
      if (m_issued) out_q.push_back(lu_issue_waddr);
      if (rst) begin
        out_q.delete();
        pres_valid = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
